// File: rtl/alu_seq.sv
// alu_seq: multi-cycle handshaked ALU execution unit.
// Accepts one request at a time over req_valid/req_ready and returns the
// result over resp_valid/resp_ready. ADD/SUB/SLT/AND/OR/XOR finish at
// acceptance; MUL (shift-and-add) and SHIFT (one bit per cycle) iterate.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  unit can accept a request (IDLE)
//   req_op     operation code: ADD=0 SUB=1 MUL=2 SLT=3 AND=4 OR=5 XOR=6 SHIFT=7
//   req_in1    operand 1
//   req_in2    operand 2
//   resp_valid result available (DONE)
//   resp_ready consumer takes result
//   resp_out   result, held until consumed, retained afterwards
//   resp_zero  resp_out == 0, registered with resp_out
//   busy       state != IDLE
//
// state | meaning
// IDLE  | waiting for a request; req_ready=1
// BUSY  | iterating MUL or SHIFT, one step per cycle
// DONE  | result presented; waiting for resp_ready
module alu_seq #(
   parameter int WORD_SIZE = 16,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_op,
   input  logic [WORD_SIZE-1:0] req_in1,
   input  logic [WORD_SIZE-1:0] req_in2,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WORD_SIZE-1:0] resp_out,
   output logic                 resp_zero,
   output logic                 busy
);

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_MUL   = 3'd2;
   localparam logic [2:0] ALU_SLT   = 3'd3;
   localparam logic [2:0] ALU_AND   = 3'd4;
   localparam logic [2:0] ALU_OR    = 3'd5;
   localparam logic [2:0] ALU_XOR   = 3'd6;
   localparam logic [2:0] ALU_SHIFT = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

   state_e               state_q, state_d;
   logic                 is_mul_q, is_mul_d;
   logic [WORD_SIZE-1:0] acc_q, acc_d;
   logic [WORD_SIZE-1:0] mcand_q, mcand_d;   // multiplicand, or the value being shifted
   logic [WORD_SIZE-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WORD_SIZE-1:0] resp_out_q, resp_out_d;
   logic                 resp_zero_q, resp_zero_d;

   logic [WORD_SIZE-1:0] quick_res;
   logic [WORD_SIZE-1:0] acc_sum;
   logic                 load_resp;
   logic [WORD_SIZE-1:0] load_val;

   always_comb begin
      quick_res = '0;
      case (req_op)
         ALU_ADD: quick_res = req_in1 + req_in2;
         ALU_SUB: quick_res = req_in1 - req_in2;
         ALU_SLT: quick_res = {{(WORD_SIZE-1){1'b0}}, ($signed(req_in1) < $signed(req_in2))};
         ALU_AND: quick_res = req_in1 & req_in2;
         ALU_OR:  quick_res = req_in1 | req_in2;
         ALU_XOR: quick_res = req_in1 ^ req_in2;
         default: quick_res = '0;
      endcase
   end

   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d     = state_q;
      is_mul_d    = is_mul_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      load_resp   = 1'b0;
      load_val    = '0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               case (req_op)
                  ALU_MUL: begin
                     state_d  = ST_BUSY;
                     is_mul_d = 1'b1;
                     acc_d    = '0;
                     mcand_d  = req_in1;
                     mplier_d = req_in2;
                     cnt_d    = CNT_W'(WORD_SIZE);
                  end
                  ALU_SHIFT: begin
                     is_mul_d = 1'b0;
                     if (req_in2 == '0) begin
                        load_resp = 1'b1;
                        load_val  = req_in1;
                     end else if (req_in2 >= WORD_SIZE'(WORD_SIZE)) begin
                        load_resp = 1'b1;
                        load_val  = '0;
                     end else begin
                        state_d = ST_BUSY;
                        mcand_d = req_in1;
                        cnt_d   = CNT_W'(req_in2);
                     end
                  end
                  default: begin
                     load_resp = 1'b1;
                     load_val  = quick_res;
                  end
               endcase
            end
         end
         ST_BUSY: begin
            cnt_d   = cnt_q - CNT_W'(1);
            mcand_d = mcand_q << 1;
            if (is_mul_q) begin
               acc_d    = acc_sum;
               mplier_d = mplier_q >> 1;
            end
            // Final step: capture the post-step value directly as the result.
            if (cnt_q == CNT_W'(1)) begin
               load_resp = 1'b1;
               load_val  = is_mul_q ? acc_sum : (mcand_q << 1);
            end
         end
         ST_DONE: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_resp) state_d = ST_DONE;
      resp_out_d  = load_resp ? load_val : resp_out_q;
      resp_zero_d = load_resp ? (load_val == '0) : resp_zero_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         is_mul_q    <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         resp_out_q  <= '0;
         resp_zero_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_mul_q    <= is_mul_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
         resp_out_q  <= resp_out_d;
         resp_zero_q <= resp_zero_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign resp_out   = resp_out_q;
   assign resp_zero  = resp_zero_q;

endmodule
